// File: rtl/nbody_seq_if.sv
// nbody_seq_if: Avalon-style slave bus plus acceleration-unit stream for nbody_seq.
interface nbody_seq_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DIMS       = 2
);
  logic                         chipselect;
  logic                         read;
  logic                         write;
  logic [ADDR_WIDTH-1:0]        addr;
  logic [DATA_WIDTH-1:0]        writedata;
  logic [DATA_WIDTH-1:0]        readdata;
  logic                         acc_in_valid;
  logic [DIMS*DATA_WIDTH-1:0]   acc_pi;
  logic [DIMS*DATA_WIDTH-1:0]   acc_pj;
  logic [DATA_WIDTH-1:0]        acc_mj;
  logic                         acc_out_valid;
  logic [DIMS*DATA_WIDTH-1:0]   acc_a;
  logic                         busy;
  logic                         irq;

  modport slave (
    input  chipselect, read, write, addr, writedata, acc_out_valid, acc_a,
    output readdata, acc_in_valid, acc_pi, acc_pj, acc_mj, busy, irq
  );

  modport master (
    output chipselect, read, write, addr, writedata, acc_out_valid, acc_a,
    input  readdata, acc_in_valid, acc_pi, acc_pj, acc_mj, busy, irq
  );
endinterface

// File: rtl/nbody_seq.sv
// nbody_seq: bus-mapped n-body sequencer. Streams (i,j) pairs to an external
// acceleration unit, accumulates results, then kicks velocities and drifts
// positions for a programmed number of steps.
// Optional: define NBODY_PERF_CNT_EN for cycle/beat counters at CTRL offsets 4/5.
module nbody_seq #(
  parameter int unsigned MAX_BODIES = 512,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DIMS       = 2,
  parameter int unsigned DT_SHIFT   = 10
) (
  input  logic        clk,
  input  logic        rst,
  nbody_seq_if.slave  bus
);
  localparam int unsigned BAW   = $clog2(MAX_BODIES);
  localparam int unsigned NW    = BAW + 1;
  localparam int unsigned RW    = ADDR_WIDTH - BAW;
  localparam int unsigned DEPTH = 1 << BAW;
  localparam int unsigned DIW   = (DIMS > 2) ? 2 : 1;
  localparam int unsigned SW    = 16;

  typedef enum logic [2:0] {S_IDLE, S_ACCEL, S_DRAIN, S_UPDATE, S_DONE} state_t;
  state_t state, state_nx;

  logic signed [DATA_WIDTH-1:0] pos_mem [DIMS][DEPTH];
  logic signed [DATA_WIDTH-1:0] vel_mem [DIMS][DEPTH];
  logic signed [DATA_WIDTH-1:0] mass_mem [DEPTH];

  logic [NW-1:0] n_bodies, iss_i, iss_j, i_nx, j_nx, j_inc, res_i, res_k, upd_b;
  logic [SW-1:0] steps, step_cnt;
  logic signed [DATA_WIDTH-1:0] acc_sum [DIMS];
  logic signed [DATA_WIDTH-1:0] sum_nx  [DIMS];
  logic signed [DATA_WIDTH-1:0] acc_a_d [DIMS];
  logic signed [DATA_WIDTH-1:0] pi_q    [DIMS];
  logic signed [DATA_WIDTH-1:0] pj_q    [DIMS];
  logic [DATA_WIDTH-1:0] rd_mux;

  // Bus decode
  logic [RW-1:0]  region;
  logic [BAW-1:0] offs;
  logic wr_en, cfg_open, go_wr, go_start, go_abort, mem_wr, ctrl_wr;
  logic run_trivial, issue_last, upd_last, step_fin, drain_done, acc_take, kick, done;
  logic [NW-1:0] n_last, n_last2;

  assign region      = bus.addr[ADDR_WIDTH-1:BAW];
  assign offs        = bus.addr[BAW-1:0];
  assign wr_en       = bus.chipselect & bus.write;
  assign cfg_open    = (state == S_IDLE) || (state == S_DONE);
  assign go_wr       = wr_en && (region == RW'(0)) && (offs == BAW'(0));
  assign go_start    = go_wr && bus.writedata[0] && cfg_open;
  assign go_abort    = go_wr && !bus.writedata[0];
  assign ctrl_wr     = wr_en && cfg_open && (region == RW'(0));
  assign mem_wr      = wr_en && cfg_open && (region != RW'(0));
  assign n_last      = n_bodies - NW'(1);
  assign n_last2     = n_bodies - NW'(2);
  assign run_trivial = (n_bodies < NW'(2)) || (steps == SW'(0));
  assign issue_last  = (iss_i == n_last) && (iss_j == n_last2);
  assign upd_last    = (upd_b == n_last);
  assign step_fin    = ((step_cnt + SW'(1)) == steps);
  assign drain_done  = (res_i == n_bodies);
  assign acc_take    = bus.acc_out_valid && !go_abort &&
                       ((state == S_ACCEL) || (state == S_DRAIN));
  assign kick        = acc_take && (res_k == n_last2);
  assign done        = (state == S_DONE);

  // Per-dimension views of the packed acceleration-unit buses
  for (genvar g = 0; g < DIMS; g++) begin : g_dim
    assign acc_a_d[g] = bus.acc_a[g*DATA_WIDTH +: DATA_WIDTH];
    assign bus.acc_pi[g*DATA_WIDTH +: DATA_WIDTH] = pi_q[g];
    assign bus.acc_pj[g*DATA_WIDTH +: DATA_WIDTH] = pj_q[g];
  end

  // Next pair: advance j skipping i, wrap to the next i
  always_comb begin
    j_inc = iss_j + NW'(1);
    if (j_inc == iss_i) j_inc = iss_j + NW'(2);
    i_nx = iss_i;
    j_nx = j_inc;
    if (j_inc >= n_bodies) begin
      i_nx = iss_i + NW'(1);
      j_nx = '0;
    end
  end

  // Running per-dimension sum including the current beat
  always_comb begin
    for (int d = 0; d < DIMS; d++) sum_nx[DIW'(d)] = acc_sum[DIW'(d)] + acc_a_d[DIW'(d)];
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    if (go_abort) state_nx = S_IDLE;
    else if (go_start) state_nx = run_trivial ? S_DONE : S_ACCEL;
    else begin
      case (state)
        S_ACCEL:  if (issue_last) state_nx = S_DRAIN;
        S_DRAIN:  if (drain_done) state_nx = S_UPDATE;
        S_UPDATE: if (upd_last) state_nx = step_fin ? S_DONE : S_ACCEL;
        default:  state_nx = state;
      endcase
    end
  end

  // State register with registered busy/irq
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      bus.busy <= 1'b0;
      bus.irq  <= 1'b0;
    end else begin
      state    <= state_nx;
      bus.busy <= (state_nx == S_ACCEL) || (state_nx == S_DRAIN) || (state_nx == S_UPDATE);
      bus.irq  <= (state_nx == S_DONE) && ((state != S_DONE) || go_start);
    end
  end

  // Control registers and step counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_bodies <= '0;
      steps    <= '0;
      step_cnt <= '0;
    end else begin
      if (ctrl_wr && offs == BAW'(2))
        n_bodies <= (bus.writedata > DATA_WIDTH'(MAX_BODIES)) ? NW'(MAX_BODIES)
                                                              : NW'(bus.writedata);
      if (ctrl_wr && offs == BAW'(3)) steps <= SW'(bus.writedata);
      if (go_start) step_cnt <= '0;
      else if (state == S_UPDATE && upd_last && !go_abort) step_cnt <= step_cnt + SW'(1);
    end
  end

  // Pair issue: operands registered from memory
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_i <= '0;
      iss_j <= '0;
      bus.acc_in_valid <= 1'b0;
      bus.acc_mj <= '0;
      for (int d = 0; d < DIMS; d++) begin
        pi_q[DIW'(d)] <= '0;
        pj_q[DIW'(d)] <= '0;
      end
    end else begin
      bus.acc_in_valid <= 1'b0;
      if (go_start || (state == S_UPDATE && upd_last)) begin
        iss_i <= '0;
        iss_j <= NW'(1);
      end else if (state == S_ACCEL && !go_abort) begin
        bus.acc_in_valid <= 1'b1;
        bus.acc_mj <= mass_mem[BAW'(iss_j)];
        for (int d = 0; d < DIMS; d++) begin
          pi_q[DIW'(d)] <= pos_mem[DIW'(d)][BAW'(iss_i)];
          pj_q[DIW'(d)] <= pos_mem[DIW'(d)][BAW'(iss_j)];
        end
        iss_i <= i_nx;
        iss_j <= j_nx;
      end
    end
  end

  // Result accumulation, one body's worth at a time in issue order
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_i <= '0;
      res_k <= '0;
      for (int d = 0; d < DIMS; d++) acc_sum[DIW'(d)] <= '0;
    end else if (go_start || (state == S_UPDATE && upd_last)) begin
      res_i <= '0;
      res_k <= '0;
      for (int d = 0; d < DIMS; d++) acc_sum[DIW'(d)] <= '0;
    end else if (acc_take) begin
      if (kick) begin
        res_i <= res_i + NW'(1);
        res_k <= '0;
        for (int d = 0; d < DIMS; d++) acc_sum[DIW'(d)] <= '0;
      end else begin
        res_k <= res_k + NW'(1);
        for (int d = 0; d < DIMS; d++) acc_sum[DIW'(d)] <= sum_nx[DIW'(d)];
      end
    end
  end

  // Drift body index walks 0..n-1 while in UPDATE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) upd_b <= '0;
    else     upd_b <= (state == S_UPDATE) ? upd_b + NW'(1) : '0;
  end

  // Body memories: bus writes when idle, kick on velocity, drift on position
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      if (region == RW'(4)) mass_mem[offs] <= bus.writedata;
      for (int d = 0; d < DIMS; d++) begin
        if (region == RW'(1 + d)) pos_mem[DIW'(d)][offs] <= bus.writedata;
        if (region == RW'(5 + d)) vel_mem[DIW'(d)][offs] <= bus.writedata;
      end
    end
    if (kick) begin
      for (int d = 0; d < DIMS; d++)
        vel_mem[DIW'(d)][BAW'(res_i)] <= vel_mem[DIW'(d)][BAW'(res_i)] +
                                         (sum_nx[DIW'(d)] >>> DT_SHIFT);
    end
    if (state == S_UPDATE && !go_abort) begin
      for (int d = 0; d < DIMS; d++)
        pos_mem[DIW'(d)][BAW'(upd_b)] <= pos_mem[DIW'(d)][BAW'(upd_b)] +
                                         (vel_mem[DIW'(d)][BAW'(upd_b)] >>> DT_SHIFT);
    end
  end

`ifdef NBODY_PERF_CNT_EN
  logic [63:0] cyc_cnt, beat_cnt;

  // Run-cycle and result-beat counters, cleared on each start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt  <= '0;
      beat_cnt <= '0;
    end else if (go_start) begin
      cyc_cnt  <= '0;
      beat_cnt <= '0;
    end else begin
      if (state == S_ACCEL || state == S_DRAIN || state == S_UPDATE) cyc_cnt <= cyc_cnt + 64'd1;
      if (bus.acc_out_valid) beat_cnt <= beat_cnt + 64'd1;
    end
  end
`endif

  // Read mux; unmapped addresses return zero
  always_comb begin
    rd_mux = '0;
    if (region == RW'(0)) begin
      case (offs)
        BAW'(1): rd_mux = DATA_WIDTH'({step_cnt, 14'd0, bus.busy, done});
        BAW'(2): rd_mux = DATA_WIDTH'(n_bodies);
        BAW'(3): rd_mux = DATA_WIDTH'(steps);
`ifdef NBODY_PERF_CNT_EN
        BAW'(4): rd_mux = DATA_WIDTH'(cyc_cnt);
        BAW'(5): rd_mux = DATA_WIDTH'(beat_cnt);
`endif
        default: rd_mux = '0;
      endcase
    end else begin
      if (region == RW'(4)) rd_mux = mass_mem[offs];
      for (int d = 0; d < DIMS; d++) begin
        if (region == RW'(1 + d)) rd_mux = pos_mem[DIW'(d)][offs];
        if (region == RW'(5 + d)) rd_mux = vel_mem[DIW'(d)][offs];
      end
    end
  end

  // Registered read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus.readdata <= '0;
    else if (bus.chipselect && bus.read) bus.readdata <= rd_mux;
  end
endmodule
